// File: rtl/sad_engine.sv
// Sum-of-absolute-differences engine: streams two blocks from synchronous RAMs, LANES pairs per read.
// Optional early exit on a partial-sum threshold is compiled in with SAD_EARLY_EXIT_EN.
module sad_engine #(
    parameter  int DATA_W = 8,
    parameter  int N      = 256,
    parameter  int LANES  = 4,
    localparam int W      = N / LANES,
    localparam int ADDR_W = (W > 1) ? $clog2(W) : 1,
    localparam int SUM_W  = DATA_W + $clog2(N)
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef SAD_EARLY_EXIT_EN
    input  logic [SUM_W-1:0]          sad_thr,
    output logic                      aborted,
`endif
    input  logic                      go,
    input  logic [LANES*DATA_W-1:0]   A_data,
    input  logic [LANES*DATA_W-1:0]   B_data,
    output logic [ADDR_W-1:0]         AB_addr,
    output logic                      AB_rd,
    output logic                      busy,
    output logic                      done,
    output logic [SUM_W-1:0]          sad
);

    localparam logic [1:0]        S_IDLE    = 2'd0;
    localparam logic [1:0]        S_RUN     = 2'd1;
    localparam logic [1:0]        S_DRAIN   = 2'd2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(W - 1);

    logic [1:0]        state_r;
    logic [ADDR_W-1:0] addr_r;
    logic              rd_r;
    logic              valid_r;
    logic [SUM_W-1:0]  acc_r;
    logic              busy_r;
    logic              done_r;
    logic [SUM_W-1:0]  sad_r;
`ifdef SAD_EARLY_EXIT_EN
    logic              aborted_r;
`endif

    logic [SUM_W-1:0]  word_sum_s;
    logic [SUM_W-1:0]  final_s;
    logic              exit_s;

    // Binary adder tree over the per-lane |a-b|; leaves sit at LANES-1 .. 2*LANES-2.
    function automatic logic [SUM_W-1:0] word_sad(
        input logic [LANES*DATA_W-1:0] a,
        input logic [LANES*DATA_W-1:0] b
    );
        logic [SUM_W-1:0]  node [2*LANES-1];
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        for (int i = 0; i < LANES; i++) begin
            x = a[i*DATA_W +: DATA_W];
            y = b[i*DATA_W +: DATA_W];
            node[LANES-1+i] = (x > y) ? SUM_W'(x - y) : SUM_W'(y - x);
        end
        for (int i = LANES - 2; i >= 0; i--) begin
            node[i] = node[2*i+1] + node[2*i+2];
        end
        return node[0];
    endfunction

    assign word_sum_s = word_sad(A_data, B_data);

    // Accumulator value including the word currently on the memory outputs.
    always_comb begin
        final_s = acc_r;
        if (valid_r) begin
            final_s = acc_r + word_sum_s;
        end else begin
            final_s = acc_r;
        end
    end

    // Early-exit decision: looks at the registered partial sum only.
    always_comb begin
        exit_s = 1'b0;
`ifdef SAD_EARLY_EXIT_EN
        if ((state_r == S_RUN) && (acc_r > sad_thr)) begin
            exit_s = 1'b1;
        end else begin
            exit_s = 1'b0;
        end
`endif
    end

    assign AB_rd   = rd_r & ~exit_s;
    assign AB_addr = addr_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign sad     = sad_r;
`ifdef SAD_EARLY_EXIT_EN
    assign aborted = aborted_r;
`endif

    // Controller and datapath registers; data read at cycle t is accumulated at the end of t+1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            addr_r    <= '0;
            rd_r      <= 1'b0;
            valid_r   <= 1'b0;
            acc_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            sad_r     <= '0;
`ifdef SAD_EARLY_EXIT_EN
            aborted_r <= 1'b0;
`endif
        end else begin
            done_r  <= 1'b0;
            valid_r <= AB_rd;
            case (state_r)
                S_IDLE: begin
                    if (go) begin
                        state_r <= S_RUN;
                        busy_r  <= 1'b1;
                        rd_r    <= 1'b1;
                        addr_r  <= '0;
                        acc_r   <= '0;
                    end
                end
                S_RUN: begin
                    if (exit_s) begin
                        // Whatever is still in flight from the RAM is dropped.
                        state_r   <= S_IDLE;
                        busy_r    <= 1'b0;
                        rd_r      <= 1'b0;
                        addr_r    <= '0;
                        done_r    <= 1'b1;
                        sad_r     <= acc_r;
`ifdef SAD_EARLY_EXIT_EN
                        aborted_r <= 1'b1;
`endif
                    end else begin
                        acc_r <= final_s;
                        if (addr_r == LAST_ADDR) begin
                            state_r <= S_DRAIN;
                            rd_r    <= 1'b0;
                            addr_r  <= '0;
                        end else begin
                            addr_r  <= addr_r + ADDR_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    state_r   <= S_IDLE;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b1;
                    acc_r     <= final_s;
                    sad_r     <= final_s;
`ifdef SAD_EARLY_EXIT_EN
                    aborted_r <= (final_s > sad_thr);
`endif
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    rd_r    <= 1'b0;
                    addr_r  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sad_engine.sv
// Scoreboard bench for sad_engine: a default (LANES=4) instance and a LANES=1 instance.
// Early-exit checks are compiled in with SAD_EARLY_EXIT_EN.
module tb_sad_engine;

    localparam int W  = 64;
    localparam int W1 = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        go  = 1'b0;
    logic        go1 = 1'b0;
    logic [31:0] a_data = 32'h0;
    logic [31:0] b_data = 32'h0;
    logic [5:0]  addr;
    logic        rd, busy, done;
    logic [15:0] sad;
    logic [7:0]  a1 = 8'h0;
    logic [7:0]  b1 = 8'h0;
    logic [7:0]  addr1;
    logic        rd1, busy1, done1;
    logic [15:0] sad1;
`ifdef SAD_EARLY_EXIT_EN
    logic [15:0] thr = 16'hFFFF;
    logic        aborted, aborted1;
`endif

    logic [31:0] mem_a [W];
    logic [31:0] mem_b [W];
    logic [7:0]  m1a [W1];
    logic [7:0]  m1b [W1];

    typedef struct {
        int sad;
        int lat;
        int reads;
        int ab;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   total = 0;
    int   bad   = 0;
    int   edge_cnt = 0;
    int   reads0 = 0;
    int   reads1 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    sad_engine dut (
        .clk(clk), .rst(rst),
`ifdef SAD_EARLY_EXIT_EN
        .sad_thr(thr), .aborted(aborted),
`endif
        .go(go), .A_data(a_data), .B_data(b_data),
        .AB_addr(addr), .AB_rd(rd), .busy(busy), .done(done), .sad(sad)
    );

    sad_engine #(.DATA_W(8), .N(256), .LANES(1)) dut1 (
        .clk(clk), .rst(rst),
`ifdef SAD_EARLY_EXIT_EN
        .sad_thr(16'hFFFF), .aborted(aborted1),
`endif
        .go(go1), .A_data(a1), .B_data(b1),
        .AB_addr(addr1), .AB_rd(rd1), .busy(busy1), .done(done1), .sad(sad1)
    );

    // Synchronous RAM models: one-cycle read latency.
    always @(posedge clk) begin
        if (rd) begin
            a_data <= mem_a[addr];
            b_data <= mem_b[addr];
        end
        if (rd1) begin
            a1 <= m1a[addr1];
            b1 <= m1b[addr1];
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for the default instance.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (rd) begin
            chk("addr_seq", addr, reads0);
            reads0++;
        end
        if (done) begin
            if (sb0.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = sb0.pop_front();
                chk("sad", sad, e.sad);
                chk("done_edge", edge_cnt, e.lat);
                chk("reads", reads0, e.reads);
                chk("busy_at_done", busy, 0);
`ifdef SAD_EARLY_EXIT_EN
                chk("aborted", aborted, e.ab);
`endif
            end
            reads0 = 0;
        end
    end

    // Monitor for the single-lane instance.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (rd1) begin
            chk("addr_seq1", addr1, reads1);
            reads1++;
        end
        if (done1) begin
            if (sb1.size() == 0) begin
                chk("spurious_done1", 1, 0);
            end else begin
                e = sb1.pop_front();
                chk("sad1", sad1, e.sad);
                chk("done_edge1", edge_cnt, e.lat);
                chk("reads1", reads1, e.reads);
                chk("busy1_at_done", busy1, 0);
`ifdef SAD_EARLY_EXIT_EN
                chk("aborted1", aborted1, e.ab);
`endif
            end
            reads1 = 0;
        end
    end

    // Called at a negedge: raises go for the next edge (e0) and logs the expected result.
    task automatic start(input int exp_sad, input int nreads, input int lat, input int ab);
        sb0.push_back('{exp_sad, edge_cnt + 1 + lat, nreads, ab});
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        for (int k = 0; k < 600 && sb0.size() != 0; k++) @(negedge clk);
        chk(name, sb0.size(), 0);
    endtask

    task automatic wait_done(input string name);
        int seen;
        seen = 0;
        for (int k = 0; k < 200 && seen == 0; k++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk(name, seen, 1);
    endtask

    task automatic fill(input logic [31:0] av, input logic [31:0] bv);
        for (int i = 0; i < W; i++) begin
            mem_a[i] = av;
            mem_b[i] = bv;
        end
    endtask

    initial begin
        logic [31:0] pat;
        int seen;
        fill(32'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_addr", addr, 0);
        chk("rst_rd", rd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sad", sad, 0);
`ifdef SAD_EARLY_EXIT_EN
        chk("rst_aborted", aborted, 0);
`endif
        rst = 1'b1;
        @(negedge clk);

        // A=0x00, B=0xFF: 256*255
        fill(32'h0, 32'hFFFF_FFFF);
        start(65280, W, W + 1, 0);
        chk("busy_in_run", busy, 1);
        wait_empty("run1_timeout");
        repeat (5) @(negedge clk);
        chk("sad_hold", sad, 65280);

        // A=B -> 0, then back-to-back start in the done cycle
        for (int i = 0; i < W; i++) begin
            pat = 32'h9E37_79B1 * i + 32'h1234_5678;
            mem_a[i] = pat;
            mem_b[i] = pat;
        end
        start(0, W, W + 1, 0);
        wait_done("b2b_first_done");
        sb0.push_back('{0, edge_cnt + 1 + W + 1, W, 0});
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk("b2b_rd_rises", rd, 1);
        wait_empty("b2b_timeout");

        // go held high for a whole run: bytes 0x10 vs 0x01 -> 15*256
        fill(32'h1010_1010, 32'h0101_0101);
        sb0.push_back('{3840, edge_cnt + 1 + W + 1, W, 0});
        go = 1'b1;
        wait_done("held_go_done");
        go = 1'b0;
        repeat (80) @(negedge clk);
        chk("held_go_no_restart", sb0.size(), 0);

        // go pulses mid-run are ignored
        start(3840, W, W + 1, 0);
        repeat (10) @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (20) @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_empty("pulse_timeout");
        repeat (80) @(negedge clk);

        // Reset at address 20 kills the run; per-word 255+64+64+255=638 -> 40832
        fill(32'h0040_80FF, 32'hFF80_4000);
        start(40832, W, W + 1, 0);
        seen = 0;
        for (int k = 0; k < 100 && seen == 0; k++) begin
            @(negedge clk);
            if (rd && addr == 6'd20) seen = 1;
        end
        chk("reach_addr20", seen, 1);
        #1 rst = 1'b0;
        #1;
        chk("kill_addr", addr, 0);
        chk("kill_rd", rd, 0);
        chk("kill_busy", busy, 0);
        chk("kill_done", done, 0);
        chk("kill_sad", sad, 0);
        sb0.delete();
        reads0 = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        start(40832, W, W + 1, 0);
        wait_empty("after_rst_timeout");

        // Single lane: A[i]=i, B[i]=255-i -> 32768, done 257 edges after go
        for (int i = 0; i < W1; i++) begin
            m1a[i] = 8'(i);
            m1b[i] = 8'(255 - i);
        end
        sb1.push_back('{32768, edge_cnt + 1 + W1 + 1, W1, 0});
        go1 = 1'b1;
        @(negedge clk);
        go1 = 1'b0;
        for (int k = 0; k < 400 && sb1.size() != 0; k++) @(negedge clk);
        chk("lane1_timeout", sb1.size(), 0);

`ifdef SAD_EARLY_EXIT_EN
        // Abort after first word: 1020 > 1000, two reads issued, done at e3
        fill(32'h0, 32'hFFFF_FFFF);
        thr = 16'd1000;
        start(1020, 2, 3, 1);
        wait_empty("abort_timeout");
        repeat (4) @(negedge clk);
        chk("aborted_hold", aborted, 1);
        // Equal to threshold is not an exit: abort one word later
        thr = 16'd1020;
        start(2040, 3, 4, 1);
        wait_empty("abort_eq_timeout");
        thr = 16'hFFFF;
        start(65280, W, W + 1, 0);
        wait_empty("no_abort_timeout");
`endif

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
